// File: rtl/swerv_trace_sink_pkg.sv
// Types shared by the retirement trace sink: the core's per-cycle trace packet,
// the serialized per-instruction record, and lane selection helpers.
package swerv_trace_sink_pkg;

  localparam int NUM_LANES = 3;
  localparam int XLEN      = 32;

  typedef logic [1:0] lane_idx_t;

  // Field order matches the core trace bundle (238 bits total).
  typedef struct packed {
    logic [NUM_LANES-1:0]      trace_rv_i_valid_ip;
    logic [NUM_LANES*XLEN-1:0] trace_rv_i_insn_ip;
    logic [NUM_LANES*XLEN-1:0] trace_rv_i_address_ip;
    logic [NUM_LANES-1:0]      trace_rv_i_exception_ip;
    logic [4:0]                trace_rv_i_ecause_ip;
    logic [NUM_LANES-1:0]      trace_rv_i_interrupt_ip;
    logic [XLEN-1:0]           trace_rv_i_tval_ip;
  } trace_pkt_t;

  typedef struct packed {
    logic            ovf;
    lane_idx_t       lane;
    logic [XLEN-1:0] insn;
    logic [XLEN-1:0] addr;
    logic            exception;
    logic            interrupt;
    logic [4:0]      ecause;
    logic [XLEN-1:0] tval;
  } trace_rec_t;

  // Lowest set lane wins, so records leave in ascending lane order.
  function automatic lane_idx_t lowest_lane(input logic [NUM_LANES-1:0] mask);
    lane_idx_t idx;
    idx = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      if (mask[k]) idx = lane_idx_t'(k);
    end
    return idx;
  endfunction

  function automatic logic [NUM_LANES-1:0] lane_bit(input lane_idx_t idx);
    return NUM_LANES'(1) << idx;
  endfunction

endpackage

// File: rtl/swerv_trace_sink_if.sv
// Bundle between the core trace outputs, the trace sink and the trace transport.
interface swerv_trace_sink_if #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
);
  import swerv_trace_sink_pkg::*;

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             trace_en;
  trace_pkt_t       trace_pkt;
  logic             rec_valid;
  logic             rec_ready;
  trace_rec_t       rec;
  logic [LVL_W-1:0] fifo_level;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    output trace_en, trace_pkt, rec_ready,
    input  rec_valid, rec, fifo_level, drop_cnt
  );

  modport slave (
    input  trace_en, trace_pkt, rec_ready,
    output rec_valid, rec, fifo_level, drop_cnt
  );

endinterface

// File: rtl/swerv_trace_sink_fifo.sv
// Generic synchronous FIFO; pointers carry a wrap bit so full/empty need no counter.
module swerv_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  // A pop frees the head slot this edge, so a push into a full FIFO is legal then.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/swerv_trace_sink.sv
// Buffers per-cycle retirement packets and serializes them into one record per
// retired lane on a valid/ready stream; overflowing packets are dropped and flagged.
module swerv_trace_sink
  import swerv_trace_sink_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input logic               clk,
  input logic               rst,
  swerv_trace_sink_if.slave bus
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  trace_pkt_t           head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [LVL_W-1:0]     level;

  logic [NUM_LANES-1:0] served_mask;
  logic [NUM_LANES-1:0] remaining;
  logic [NUM_LANES-1:0] remaining_after;
  lane_idx_t            lane;
  logic                 handshake;
  logic                 pop;
  logic                 want_push;
  logic                 push;
  logic                 drop;
  logic                 ovf_pending;
  logic [CNT_W-1:0]     drop_cnt;
  logic                 lane_cause;
  trace_rec_t           rec_d;

  swerv_trace_fifo #(
    .WIDTH ($bits(trace_pkt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (bus.trace_pkt),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  // Lanes still owed for the head packet are its valid bits minus those already
  // handshaked; the head pops on the handshake that leaves nothing behind.
  always_comb begin
    remaining = '0;
    if (!fifo_empty) remaining = head.trace_rv_i_valid_ip & ~served_mask;
    lane            = lowest_lane(remaining);
    remaining_after = remaining & ~lane_bit(lane);
    handshake       = (|remaining) && bus.rec_ready;
    pop             = handshake && (remaining_after == '0);
    want_push       = bus.trace_en && (|bus.trace_pkt.trace_rv_i_valid_ip);
    push            = want_push && (!fifo_full || pop);
    drop            = want_push && fifo_full && !pop;
  end

  always_comb begin
    rec_d      = '0;
    lane_cause = 1'b0;
    if (|remaining) begin
      lane_cause      = head.trace_rv_i_exception_ip[lane] | head.trace_rv_i_interrupt_ip[lane];
      rec_d.ovf       = ovf_pending;
      rec_d.lane      = lane;
      rec_d.insn      = head.trace_rv_i_insn_ip[XLEN*int'(lane) +: XLEN];
      rec_d.addr      = head.trace_rv_i_address_ip[XLEN*int'(lane) +: XLEN];
      rec_d.exception = head.trace_rv_i_exception_ip[lane];
      rec_d.interrupt = head.trace_rv_i_interrupt_ip[lane];
      if (lane_cause) begin
        rec_d.ecause = head.trace_rv_i_ecause_ip;
        rec_d.tval   = head.trace_rv_i_tval_ip;
      end
    end
  end

  // A drop in the same cycle as the ovf record's handshake must win, so the
  // flag is not lost for the packets that were just discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      served_mask <= '0;
      drop_cnt    <= '0;
      ovf_pending <= 1'b0;
    end else begin
      if (pop)
        served_mask <= '0;
      else if (handshake)
        served_mask <= served_mask | lane_bit(lane);
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
      if (drop)
        ovf_pending <= 1'b1;
      else if (handshake && ovf_pending)
        ovf_pending <= 1'b0;
    end
  end

  assign bus.rec_valid  = |remaining;
  assign bus.rec        = rec_d;
  assign bus.fifo_level = level;
  assign bus.drop_cnt   = drop_cnt;

endmodule

// File: tb/tb_swerv_trace_sink.sv
// Bench for swerv_trace_sink: directed vector table, reset-mid-packet sequence,
// then randomized traffic compared against a queue-based reference model.
module tb_swerv_trace_sink;
  import swerv_trace_sink_pkg::*;

  localparam int          DEPTH  = 4;
  localparam int          CNT_W  = 16;
  localparam logic [4:0]  ECAUSE = 5'd2;
  localparam logic [31:0] TVAL   = 32'h0000_DEAD;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  swerv_trace_sink_if #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  swerv_trace_sink #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One row = inputs for a cycle plus the outputs expected after that edge.
  typedef struct {
    logic        en;
    logic [2:0]  vld;
    logic [7:0]  tag;
    logic [2:0]  exc;
    logic [2:0]  intr;
    logic        rdy;
    logic        e_valid;
    logic [1:0]  e_lane;
    logic [7:0]  e_tag;
    logic        e_exc;
    logic        e_intr;
    logic        e_ovf;
    int          e_level;
    int          e_drop;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] insn_of(input logic [7:0] tag, input int k);
    return {16'hA5A5, tag, 8'(k)};
  endfunction

  function automatic logic [31:0] addr_of(input logic [7:0] tag, input int k);
    return {16'h8000, tag, 8'(4 * k)};
  endfunction

  function automatic trace_pkt_t make_pkt(input logic [7:0] tag, input logic [2:0] vld,
                                          input logic [2:0] exc, input logic [2:0] intr);
    trace_pkt_t p;
    p = '0;
    p.trace_rv_i_valid_ip     = vld;
    p.trace_rv_i_exception_ip = exc;
    p.trace_rv_i_interrupt_ip = intr;
    p.trace_rv_i_ecause_ip    = ECAUSE;
    p.trace_rv_i_tval_ip      = TVAL;
    for (int k = 0; k < 3; k++) begin
      p.trace_rv_i_insn_ip[32*k +: 32]    = insn_of(tag, k);
      p.trace_rv_i_address_ip[32*k +: 32] = addr_of(tag, k);
    end
    return p;
  endfunction

  function automatic vec_t mk(input logic en, input logic [2:0] vld, input logic [7:0] tag,
                              input logic [2:0] exc, input logic [2:0] intr, input logic rdy,
                              input logic ev, input logic [1:0] el, input logic [7:0] et,
                              input logic eexc, input logic eintr, input logic eovf,
                              input int elev, input int edrop);
    vec_t v;
    v.en = en; v.vld = vld; v.tag = tag; v.exc = exc; v.intr = intr; v.rdy = rdy;
    v.e_valid = ev; v.e_lane = el; v.e_tag = et; v.e_exc = eexc; v.e_intr = eintr;
    v.e_ovf = eovf; v.e_level = elev; v.e_drop = edrop;
    return v;
  endfunction

  function automatic trace_rec_t table_rec(input vec_t v);
    trace_rec_t r;
    r = '0;
    if (v.e_valid) begin
      r.ovf       = v.e_ovf;
      r.lane      = v.e_lane;
      r.insn      = insn_of(v.e_tag, int'(v.e_lane));
      r.addr      = addr_of(v.e_tag, int'(v.e_lane));
      r.exception = v.e_exc;
      r.interrupt = v.e_intr;
      r.ecause    = (v.e_exc | v.e_intr) ? ECAUSE : 5'd0;
      r.tval      = (v.e_exc | v.e_intr) ? TVAL : 32'd0;
    end
    return r;
  endfunction

  // Record built straight from the lane-field rules of a whole packet.
  function automatic trace_rec_t build_rec(input trace_pkt_t p, input int k, input logic ovf);
    trace_rec_t r;
    logic       cause;
    r         = '0;
    cause     = p.trace_rv_i_exception_ip[k] | p.trace_rv_i_interrupt_ip[k];
    r.ovf       = ovf;
    r.lane      = 2'(k);
    r.insn      = p.trace_rv_i_insn_ip[32*k +: 32];
    r.addr      = p.trace_rv_i_address_ip[32*k +: 32];
    r.exception = p.trace_rv_i_exception_ip[k];
    r.interrupt = p.trace_rv_i_interrupt_ip[k];
    r.ecause    = cause ? p.trace_rv_i_ecause_ip : 5'd0;
    r.tval      = cause ? p.trace_rv_i_tval_ip : 32'd0;
    return r;
  endfunction

  function automatic int nth_set_lane(input logic [2:0] v, input int n);
    int seen;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      if (v[k]) begin
        if (seen == n) return k;
        seen++;
      end
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input trace_pkt_t pkt, input logic rdy);
    bus.trace_en  = en;
    bus.trace_pkt = pkt;
    bus.rec_ready = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic checkState(input string name, input logic exp_valid, input trace_rec_t exp_rec,
                            input int exp_level, input int exp_drop);
    checkOutput({name, " rec_valid"}, 128'(bus.rec_valid), 128'(exp_valid));
    checkOutput({name, " rec"}, 128'(bus.rec), 128'(exp_rec));
    checkOutput({name, " fifo_level"}, 128'(bus.fifo_level), 128'(exp_level));
    checkOutput({name, " drop_cnt"}, 128'(bus.drop_cnt), 128'(exp_drop));
  endtask

  task automatic doReset();
    applyStimulus(1'b0, '0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic buildVectors();
    // Fill to full with ready low, then two drops raise ovf on the head record.
    vecs.push_back(mk(1, 3'b001,  1, 0, 0,      0, 1, 0,  1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 3'b001,  2, 0, 0,      0, 1, 0,  1, 0, 0, 0, 2, 0));
    vecs.push_back(mk(1, 3'b001,  3, 0, 0,      0, 1, 0,  1, 0, 0, 0, 3, 0));
    vecs.push_back(mk(1, 3'b001,  4, 0, 0,      0, 1, 0,  1, 0, 0, 0, 4, 0));
    vecs.push_back(mk(1, 3'b001,  5, 0, 0,      0, 1, 0,  1, 0, 0, 1, 4, 1));
    vecs.push_back(mk(1, 3'b001,  6, 0, 0,      0, 1, 0,  1, 0, 0, 1, 4, 2));
    vecs.push_back(mk(0, 3'b000,  0, 0, 0,      1, 1, 0,  2, 0, 0, 0, 3, 2));
    vecs.push_back(mk(1, 3'b001,  7, 0, 0,      0, 1, 0,  2, 0, 0, 0, 4, 2));
    // Full FIFO, last lane handshakes while a new packet arrives: accepted.
    vecs.push_back(mk(1, 3'b001,  8, 0, 0,      1, 1, 0,  3, 0, 0, 0, 4, 2));
    vecs.push_back(mk(0, 3'b000,  0, 0, 0,      1, 1, 0,  4, 0, 0, 0, 3, 2));
    vecs.push_back(mk(0, 3'b000,  0, 0, 0,      1, 1, 0,  7, 0, 0, 0, 2, 2));
    vecs.push_back(mk(0, 3'b000,  0, 0, 0,      1, 1, 0,  8, 0, 0, 0, 1, 2));
    vecs.push_back(mk(0, 3'b000,  0, 0, 0,      1, 0, 0,  0, 0, 0, 0, 0, 2));
    // Disabled capture ignores a valid packet.
    vecs.push_back(mk(0, 3'b111, 12, 0, 0,      1, 0, 0,  0, 0, 0, 0, 0, 2));
    // Exception lane under 1010 backpressure.
    vecs.push_back(mk(1, 3'b011,  9, 3'b010, 0, 0, 1, 0,  9, 0, 0, 0, 1, 2));
    vecs.push_back(mk(0, 3'b000,  0, 0, 0,      0, 1, 0,  9, 0, 0, 0, 1, 2));
    vecs.push_back(mk(0, 3'b000,  0, 0, 0,      1, 1, 1,  9, 1, 0, 0, 1, 2));
    vecs.push_back(mk(0, 3'b000,  0, 0, 0,      0, 1, 1,  9, 1, 0, 0, 1, 2));
    vecs.push_back(mk(0, 3'b000,  0, 0, 0,      1, 0, 0,  0, 0, 0, 0, 0, 2));
    // Three lanes back to back with an interrupt on lane 2.
    vecs.push_back(mk(1, 3'b111, 10, 0, 3'b100, 1, 1, 0, 10, 0, 0, 0, 1, 2));
    vecs.push_back(mk(0, 3'b000,  0, 0, 0,      1, 1, 1, 10, 0, 0, 0, 1, 2));
    vecs.push_back(mk(0, 3'b000,  0, 0, 0,      1, 1, 2, 10, 0, 1, 0, 1, 2));
    vecs.push_back(mk(0, 3'b000,  0, 0, 0,      1, 0, 0,  0, 0, 0, 0, 0, 2));
    // Sparse valid 101 skips lane 1.
    vecs.push_back(mk(1, 3'b101, 11, 0, 0,      1, 1, 0, 11, 0, 0, 0, 1, 2));
    vecs.push_back(mk(0, 3'b000,  0, 0, 0,      1, 1, 2, 11, 0, 0, 0, 1, 2));
    vecs.push_back(mk(0, 3'b000,  0, 0, 0,      1, 0, 0,  0, 0, 0, 0, 0, 2));
    // Drop in the same cycle as the ovf record's handshake keeps ovf set.
    vecs.push_back(mk(1, 3'b011, 13, 0, 0,      0, 1, 0, 13, 0, 0, 0, 1, 2));
    vecs.push_back(mk(1, 3'b001, 14, 0, 0,      0, 1, 0, 13, 0, 0, 0, 2, 2));
    vecs.push_back(mk(1, 3'b001, 15, 0, 0,      0, 1, 0, 13, 0, 0, 0, 3, 2));
    vecs.push_back(mk(1, 3'b001, 16, 0, 0,      0, 1, 0, 13, 0, 0, 0, 4, 2));
    vecs.push_back(mk(0, 3'b001, 19, 0, 0,      0, 1, 0, 13, 0, 0, 0, 4, 2));
    vecs.push_back(mk(1, 3'b001, 17, 0, 0,      0, 1, 0, 13, 0, 0, 1, 4, 3));
    vecs.push_back(mk(1, 3'b001, 18, 0, 0,      1, 1, 1, 13, 0, 0, 1, 4, 4));
    vecs.push_back(mk(0, 3'b000,  0, 0, 0,      1, 1, 0, 14, 0, 0, 0, 3, 4));
    vecs.push_back(mk(0, 3'b000,  0, 0, 0,      1, 1, 0, 15, 0, 0, 0, 2, 4));
    vecs.push_back(mk(0, 3'b000,  0, 0, 0,      1, 1, 0, 16, 0, 0, 0, 1, 4));
    vecs.push_back(mk(0, 3'b000,  0, 0, 0,      1, 0, 0,  0, 0, 0, 0, 0, 4));
  endtask

  task automatic resetMidPacket();
    applyStimulus(1'b1, make_pkt(8'd20, 3'b111, 3'b000, 3'b000), 1'b1);
    tick();
    checkOutput("mid lane0 valid", 128'(bus.rec_valid), 128'(1));
    checkOutput("mid lane0 insn", 128'(bus.rec.insn), 128'(insn_of(8'd20, 0)));
    applyStimulus(1'b0, '0, 1'b1);
    tick();
    checkOutput("mid lane1 insn", 128'(bus.rec.insn), 128'(insn_of(8'd20, 1)));
    rst = 1'b1;
    tick();
    checkState("mid reset", 1'b0, '0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic randomTest();
    trace_pkt_t mq[$];
    trace_pkt_t pkt;
    trace_rec_t exp_rec;
    logic       en;
    logic       rdy;
    logic       exp_valid;
    logic       last;
    logic       m_ovf;
    int         emitted;
    int         m_drop;
    int         lane;
    emitted = 0;
    m_ovf   = 1'b0;
    m_drop  = 0;
    for (int c = 0; c < 600; c++) begin
      en = ($urandom_range(0, 9) != 0);
      pkt.trace_rv_i_valid_ip     = 3'($urandom_range(0, 7));
      pkt.trace_rv_i_insn_ip      = {$urandom(), $urandom(), $urandom()};
      pkt.trace_rv_i_address_ip   = {$urandom(), $urandom(), $urandom()};
      pkt.trace_rv_i_exception_ip = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
      pkt.trace_rv_i_interrupt_ip = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
      pkt.trace_rv_i_ecause_ip    = 5'($urandom_range(0, 31));
      pkt.trace_rv_i_tval_ip      = $urandom();
      if (((c / 50) % 3) == 1) rdy = ($urandom_range(0, 5) == 0);
      else                     rdy = ($urandom_range(0, 3) != 0);

      exp_valid = (mq.size() != 0);
      exp_rec   = '0;
      last      = 1'b0;
      if (exp_valid) begin
        lane    = nth_set_lane(mq[0].trace_rv_i_valid_ip, emitted);
        exp_rec = build_rec(mq[0], lane, m_ovf);
        last    = (emitted == $countones(mq[0].trace_rv_i_valid_ip) - 1);
      end

      applyStimulus(en, pkt, rdy);
      checkState($sformatf("rnd%0d", c), exp_valid, exp_rec, mq.size(), m_drop);

      if (exp_valid && rdy) begin
        m_ovf = 1'b0;
        emitted++;
        if (last) begin
          void'(mq.pop_front());
          emitted = 0;
        end
      end
      if (en && (pkt.trace_rv_i_valid_ip != 3'b000)) begin
        if (mq.size() < DEPTH) mq.push_back(pkt);
        else begin
          if (m_drop < (1 << CNT_W) - 1) m_drop++;
          m_ovf = 1'b1;
        end
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    buildVectors();
    doReset();
    checkState("reset", 1'b0, '0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].en, make_pkt(vecs[i].tag, vecs[i].vld, vecs[i].exc, vecs[i].intr),
                    vecs[i].rdy);
      tick();
      checkState($sformatf("vec%0d", i), vecs[i].e_valid, table_rec(vecs[i]),
                 vecs[i].e_level, vecs[i].e_drop);
    end

    resetMidPacket();
    randomTest();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
